// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard over the shared open-drain ps2_clk/ps2_data
// lines. The *_oe outputs tell the pad logic to pull a line low.
// Optional feature: define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a frame
// the device never finishes (default build: no watchdog, waits indefinitely).
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 750000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam logic [19:0] INHIBIT_LIM = 20'(INHIBIT_CYCLES);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [8:0]  frame_q, frame_d;
  logic        data_drive_q, data_drive_d;
  logic        ack_err_q, ack_err_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  // Two-flop synchronisers for both pads plus a delayed clk copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // FSM state, counters and frame shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitcnt_q     <= '0;
      frame_q      <= '0;
      data_drive_q <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitcnt_q     <= bitcnt_d;
      frame_q      <= frame_d;
      data_drive_q <= data_drive_d;
      ack_err_q    <= ack_err_d;
    end
  end

  // Next-state logic and line/handshake outputs; outputs depend only on state so
  // an asynchronous reset releases both lines at once.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitcnt_d     = bitcnt_q;
    frame_d      = frame_q;
    data_drive_d = data_drive_q;
    ack_err_d    = ack_err_q;
    ps2_clk_oe   = 1'b0;
    ps2_data_oe  = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          frame_d   = {~^tx_byte, tx_byte};
          ack_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q >= INHIBIT_LIM) begin
          // Start bit goes down while the clock is still held, then release clock.
          ps2_data_oe = 1'b1;
          state_d     = REQ;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      REQ: begin
        ps2_data_oe  = 1'b1;
        bitcnt_d     = '0;
        data_drive_d = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
        cnt_d        = 20'd1;
`endif
        state_d      = SEND;
      end
      SEND: begin
        ps2_data_oe = data_drive_q;
        if (fall) begin
          if (bitcnt_q == 4'd9) begin
            // Stop bit: let the line float high.
            data_drive_d = 1'b0;
            state_d      = ACK;
          end else begin
            // Open-drain: pull low for a 0 bit.
            data_drive_d = ~frame_q[0];
            frame_d      = {1'b0, frame_q[8:1]};
            bitcnt_d     = bitcnt_q + 4'd1;
          end
        end
      end
      ACK: begin
        if (fall) begin
          ack_err_d = data_sync_q;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog runs from REQ entry; never restarted within a frame.
    if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
      if (cnt_q >= TIMEOUT_LIM - 20'd1) begin
        state_d   = DONE;
        ack_err_d = 1'b1;
      end else begin
        cnt_d = sat_inc(cnt_q);
      end
    end
`endif
  end

  assign ack_err = ack_err_q;

endmodule
